// File: rtl/pc_alu_exec_unit.sv
// pc_alu_exec_unit
//   Fetch-stage program counter combined with the execute-stage ALU control
//   decode and the ALU datapath of a 5-stage MIPS-style pipeline.
//
//   The PC register is the only state. The ALU control and the ALU itself
//   are purely combinational.
//
// Ports:
//   clk            in   1   rising-edge clock
//   clr            in   1   synchronous active-high reset (PC only)
//   pc_hold        in   1   stall: PC keeps its value
//   branch_taken   in   1   redirect PC to branch_target (overrides pc_hold)
//   branch_target  in  32   redirect address (forced word-aligned)
//   pc_out         out 32   current PC / instruction memory address
//   pc_plus_step   out 32   pc_out + PC_STEP
//   alu_op         in   4   ALU op from main control
//   funct          in   6   instruction[5:0]
//   shamt          in   5   instruction[10:6]
//   oper1          in  32   ALU operand 1 (rs data)
//   oper2          in  32   ALU operand 2 (rt data or sign-extended immediate)
//   ctrl_command   out  4   decoded ALU command
//   result         out 32   ALU result
//   overflow       out  1   signed overflow (ADD/SUB only)
//   zero           out  1   result == 0
module pc_alu_exec_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        pc_hold,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus_step,
  input  logic [3:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] oper1,
  input  logic [31:0] oper2,
  output logic [3:0]  ctrl_command,
  output logic [31:0] result,
  output logic        overflow,
  output logic        zero
);

  // ALU command encoding
  localparam logic [3:0] CMD_AND  = 4'b0000;
  localparam logic [3:0] CMD_OR   = 4'b0001;
  localparam logic [3:0] CMD_ADD  = 4'b0010;
  localparam logic [3:0] CMD_XOR  = 4'b0011;
  localparam logic [3:0] CMD_SLL  = 4'b0100;
  localparam logic [3:0] CMD_SRL  = 4'b0101;
  localparam logic [3:0] CMD_SUB  = 4'b0110;
  localparam logic [3:0] CMD_SLT  = 4'b0111;
  localparam logic [3:0] CMD_SRA  = 4'b1000;
  localparam logic [3:0] CMD_SLTU = 4'b1001;
  localparam logic [3:0] CMD_LUI  = 4'b1010;
  localparam logic [3:0] CMD_NOR  = 4'b1100;

  // Signed overflow of a + b: same-sign operands giving a different-sign sum.
  function automatic logic add_ovf(input logic signed [31:0] a,
                                   input logic signed [31:0] b,
                                   input logic signed [31:0] s);
    return (a[31] == b[31]) && (s[31] != a[31]);
  endfunction

  // Signed overflow of a - b: differing operand signs and the result sign
  // differing from the minuend.
  function automatic logic sub_ovf(input logic signed [31:0] a,
                                   input logic signed [31:0] b,
                                   input logic signed [31:0] d);
    return (a[31] != b[31]) && (d[31] != a[31]);
  endfunction

  // ---------------------------------------------------------------------
  // Program counter
  // ---------------------------------------------------------------------
  logic [31:0] pc_q, pc_d;

  // The low target bits are dropped: fetch addresses are always word aligned.
  logic unused_tgt_lsbs;
  assign unused_tgt_lsbs = ^branch_target[1:0];

  always_comb begin
    pc_d = pc_q + PC_STEP;
    if (branch_taken)
      pc_d = {branch_target[31:2], 2'b00};
    else if (pc_hold)
      pc_d = pc_q;
  end

  always_ff @(posedge clk) begin
    if (clr) pc_q <= PC_RESET;
    else     pc_q <= pc_d;
  end

  assign pc_out       = pc_q;
  assign pc_plus_step = pc_q + PC_STEP;

  // ---------------------------------------------------------------------
  // ALU control decode
  // ---------------------------------------------------------------------
  always_comb begin
    ctrl_command = CMD_ADD;
    case (alu_op)
      4'b0000: ctrl_command = CMD_ADD;
      4'b0001: ctrl_command = CMD_SUB;
      4'b0010: begin
        case (funct)
          6'b100000, 6'b100001: ctrl_command = CMD_ADD;
          6'b100010, 6'b100011: ctrl_command = CMD_SUB;
          6'b100100:            ctrl_command = CMD_AND;
          6'b100101:            ctrl_command = CMD_OR;
          6'b100110:            ctrl_command = CMD_XOR;
          6'b100111:            ctrl_command = CMD_NOR;
          6'b101010:            ctrl_command = CMD_SLT;
          6'b101011:            ctrl_command = CMD_SLTU;
          6'b000000:            ctrl_command = CMD_SLL;
          6'b000010:            ctrl_command = CMD_SRL;
          6'b000011:            ctrl_command = CMD_SRA;
          default:              ctrl_command = CMD_ADD;
        endcase
      end
      4'b0011: ctrl_command = CMD_AND;
      4'b0100: ctrl_command = CMD_OR;
      4'b0101: ctrl_command = CMD_SLT;
      4'b0110: ctrl_command = CMD_XOR;
      4'b0111: ctrl_command = CMD_LUI;
      default: ctrl_command = CMD_ADD;
    endcase
  end

  // ---------------------------------------------------------------------
  // ALU datapath
  // ---------------------------------------------------------------------
  logic signed [31:0] op1_s, op2_s, sum_s, diff_s;

  assign op1_s  = oper1;
  assign op2_s  = oper2;
  assign sum_s  = op1_s + op2_s;
  assign diff_s = op1_s - op2_s;

  always_comb begin
    result   = 32'h0;
    overflow = 1'b0;
    case (ctrl_command)
      CMD_ADD: begin
        result   = sum_s;
        overflow = add_ovf(op1_s, op2_s, sum_s);
      end
      CMD_SUB: begin
        result   = diff_s;
        overflow = sub_ovf(op1_s, op2_s, diff_s);
      end
      CMD_AND:  result = oper1 & oper2;
      CMD_OR:   result = oper1 | oper2;
      CMD_XOR:  result = oper1 ^ oper2;
      CMD_NOR:  result = ~(oper1 | oper2);
      CMD_SLT:  result = {31'h0, (op1_s < op2_s)};
      CMD_SLTU: result = {31'h0, (oper1 < oper2)};
      CMD_SLL:  result = oper2 << shamt;
      CMD_SRL:  result = oper2 >> shamt;
      CMD_SRA:  result = $unsigned(op2_s >>> shamt);
      CMD_LUI:  result = {oper2[15:0], 16'h0000};
      default:  result = 32'h0;
    endcase
  end

  assign zero = (result == 32'h0);

endmodule

// File: tb/tb_pc_alu_exec_unit.sv
module tb_pc_alu_exec_unit;

  logic        clk = 1'b0;
  logic        clr, pc_hold, branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc_out, pc_plus_step;
  logic [3:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] oper1, oper2;
  logic [3:0]  ctrl_command;
  logic [31:0] result;
  logic        overflow, zero;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        ovf;
    logic        zr;
  } alu_exp_t;

  logic [31:0] pc_q[$];
  alu_exp_t    alu_q[$];

  pc_alu_exec_unit #(.PC_RESET(32'h0), .PC_STEP(32'd4)) dut (
    .clk           (clk),
    .clr           (clr),
    .pc_hold       (pc_hold),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc_out        (pc_out),
    .pc_plus_step  (pc_plus_step),
    .alu_op        (alu_op),
    .funct         (funct),
    .shamt         (shamt),
    .oper1         (oper1),
    .oper2         (oper2),
    .ctrl_command  (ctrl_command),
    .result        (result),
    .overflow      (overflow),
    .zero          (zero)
  );

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one PC cycle; the expected PC after the edge is queued first.
  task automatic pc_cycle(input string tag, input logic c, input logic h,
                          input logic b, input logic [31:0] tgt,
                          input logic [31:0] exp);
    logic [31:0] e;
    clr = c; pc_hold = h; branch_taken = b; branch_target = tgt;
    pc_q.push_back(exp);
    @(posedge clk);
    #1;
    e = pc_q.pop_front();
    check32({tag, ".pc"}, pc_out, e);
    check32({tag, ".pc_plus"}, pc_plus_step, e + 32'd4);
  endtask

  task automatic alu_case(input string tag, input logic [3:0] op, input logic [5:0] fn,
                          input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] x_ctrl, input logic [31:0] x_res,
                          input logic x_ovf, input logic x_zero);
    alu_exp_t e;
    alu_op = op; funct = fn; shamt = sh; oper1 = a; oper2 = b;
    alu_q.push_back('{ctrl: x_ctrl, res: x_res, ovf: x_ovf, zr: x_zero});
    #1;
    e = alu_q.pop_front();
    check32({tag, ".ctrl"}, {28'h0, ctrl_command}, {28'h0, e.ctrl});
    check32({tag, ".result"}, result, e.res);
    check32({tag, ".overflow"}, {31'h0, overflow}, {31'h0, e.ovf});
    check32({tag, ".zero"}, {31'h0, zero}, {31'h0, e.zr});
  endtask

  initial begin
    clr = 1'b1; pc_hold = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    alu_op = 4'h0; funct = 6'h0; shamt = 5'h0; oper1 = 32'h0; oper2 = 32'h0;
    @(negedge clk);

    // Reset and increment
    pc_cycle("reset", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0000);
    pc_cycle("inc1",  1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0004);
    pc_cycle("inc2",  1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0008);
    // Hold and branch priority
    pc_cycle("hold1", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0008);
    pc_cycle("hold2", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0008);
    pc_cycle("br_over_hold", 1'b0, 1'b1, 1'b1, 32'h0000_0103, 32'h0000_0100);
    pc_cycle("clr_over_br",  1'b1, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_0000);
    pc_cycle("inc3",  1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0004);
    pc_cycle("inc4",  1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0008);
    pc_cycle("inc5",  1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_000C);
    // PC wrap
    pc_cycle("br_top", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    pc_cycle("wrap",   1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0000);

    // R-type decode
    alu_case("r_add",  4'b0010, 6'b100000, 5'd0, 32'd7, 32'd5, 4'b0010, 32'd12, 1'b0, 1'b0);
    alu_case("r_sub",  4'b0010, 6'b100010, 5'd0, 32'd7, 32'd5, 4'b0110, 32'd2,  1'b0, 1'b0);
    alu_case("r_and",  4'b0010, 6'b100100, 5'd0, 32'd7, 32'd5, 4'b0000, 32'd5,  1'b0, 1'b0);
    alu_case("r_or",   4'b0010, 6'b100101, 5'd0, 32'd7, 32'd5, 4'b0001, 32'd7,  1'b0, 1'b0);
    alu_case("r_xor",  4'b0010, 6'b100110, 5'd0, 32'd7, 32'd5, 4'b0011, 32'd2,  1'b0, 1'b0);
    alu_case("r_nor",  4'b0010, 6'b100111, 5'd0, 32'd7, 32'd5, 4'b1100, 32'hFFFF_FFF8, 1'b0, 1'b0);
    alu_case("r_slt",  4'b0010, 6'b101010, 5'd0, 32'd7, 32'd5, 4'b0111, 32'd0,  1'b0, 1'b1);
    alu_case("r_dflt", 4'b0010, 6'b111111, 5'd0, 32'd7, 32'd5, 4'b0010, 32'd12, 1'b0, 1'b0);

    // Overflow and signed compare
    alu_case("add_ovf",  4'b0000, 6'h0, 5'd0, 32'h7FFF_FFFF, 32'd1, 4'b0010, 32'h8000_0000, 1'b1, 1'b0);
    alu_case("addu_ovf", 4'b0010, 6'b100001, 5'd0, 32'h7FFF_FFFF, 32'd1, 4'b0010, 32'h8000_0000, 1'b1, 1'b0);
    alu_case("sub_ovf",  4'b0001, 6'h0, 5'd0, 32'h8000_0000, 32'd1, 4'b0110, 32'h7FFF_FFFF, 1'b1, 1'b0);
    alu_case("sub_zero", 4'b0001, 6'h0, 5'd0, 32'd5, 32'd5, 4'b0110, 32'd0, 1'b0, 1'b1);
    alu_case("slt_neg",  4'b0101, 6'h0, 5'd0, 32'hFFFF_FFFF, 32'd1, 4'b0111, 32'd1, 1'b0, 1'b0);
    alu_case("sltu_neg", 4'b0010, 6'b101011, 5'd0, 32'hFFFF_FFFF, 32'd1, 4'b1001, 32'd0, 1'b0, 1'b1);
    alu_case("op_and",   4'b0011, 6'h0, 5'd0, 32'h0000_00F0, 32'h0000_0F0F, 4'b0000, 32'd0, 1'b0, 1'b1);
    alu_case("op_hi",    4'b1010, 6'h0, 5'd0, 32'd3, 32'd4, 4'b0010, 32'd7, 1'b0, 1'b0);

    // Shifts and LUI
    alu_case("sll", 4'b0010, 6'b000000, 5'd4, 32'h0, 32'h8000_00F0, 4'b0100, 32'h0000_0F00, 1'b0, 1'b0);
    alu_case("srl", 4'b0010, 6'b000010, 5'd4, 32'h0, 32'h8000_00F0, 4'b0101, 32'h0800_000F, 1'b0, 1'b0);
    alu_case("sra", 4'b0010, 6'b000011, 5'd4, 32'h0, 32'h8000_00F0, 4'b1000, 32'hF800_000F, 1'b0, 1'b0);
    alu_case("lui", 4'b0111, 6'h0, 5'd0, 32'h0, 32'h0000_1234, 4'b1010, 32'h1234_0000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
